vc_router_bypass_pipe: RTL

- Parametrised successor to the single-mode router bypass shim. Sits between the fabric links (x side) and one VC router instance (y side).
- Two modes. NORMAL passes flits and credits straight between x and y. BYPASS loops each x input channel back to the same-index x output through a BYP_STAGES-deep register pipe and gates the router clock.
- Mode changes go through a quiesce/drain state machine, so no flit or credit is lost or duplicated at switchover.
- Counts flits that cross the bypass path.

---
 rtl/vc_router_bypass_pipe_if.sv | 55 +++++
 rtl/vc_router_bypass_pipe.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vc_router_bypass_pipe_if.sv
// Bus bundle between the fabric links (x side), the bypass shim and one VC
// router instance (y side).
//
// Flow control is credit based with no backpressure. A flit is transferred
// in every cycle in which its channel's valid bit is 1. Each credit bit
// returns one buffer slot for one VC in the cycle it is 1. There is no
// ready signal, so nothing can stall: a flit or credit that is presented
// must be taken in that cycle.
//
// Signals:
//   bypassReq     requested mode, 1 = bypass (into shim)
//   bypassActive  1 while the x outputs come from the bypass pipe
//   routerClkEn   clock enable for the router's clock buffer
//   x_in*/x_out*  link-side flits, valids and credits
//   y_in*/y_out*  router-side flits, valids and credits
//   bypFlitCount  flits accepted into the bypass pipe (wraps)
//   dbgState      shim FSM state for debug and checkers
// slave modport = the shim, master modport = whatever drives the shim.
interface vc_router_bypass_pipe_if #(
  parameter int NUM_CH = 5,
  parameter int NUM_VC = 2,
  parameter int FLIT_W = 55
);
  logic                       bypassReq;
  logic                       bypassActive;
  logic                       routerClkEn;
  logic [NUM_CH*FLIT_W-1:0]   x_inFlit;
  logic [NUM_CH-1:0]          x_inValid;
  logic [NUM_CH*NUM_VC-1:0]   x_inCredit;
  logic [NUM_CH*FLIT_W-1:0]   x_outFlit;
  logic [NUM_CH-1:0]          x_outValid;
  logic [NUM_CH*NUM_VC-1:0]   x_outCredit;
  logic [NUM_CH*FLIT_W-1:0]   y_inFlit;
  logic [NUM_CH-1:0]          y_inValid;
  logic [NUM_CH*NUM_VC-1:0]   y_inCredit;
  logic [NUM_CH*FLIT_W-1:0]   y_outFlit;
  logic [NUM_CH-1:0]          y_outValid;
  logic [NUM_CH*NUM_VC-1:0]   y_outCredit;
  logic [31:0]                bypFlitCount;
  logic [1:0]                 dbgState;

  modport slave (
    input  bypassReq, x_inFlit, x_inValid, x_outCredit,
           y_inCredit, y_outFlit, y_outValid,
    output bypassActive, routerClkEn, x_inCredit, x_outFlit, x_outValid,
           y_inFlit, y_inValid, y_outCredit, bypFlitCount, dbgState
  );

  modport master (
    output bypassReq, x_inFlit, x_inValid, x_outCredit,
           y_inCredit, y_outFlit, y_outValid,
    input  bypassActive, routerClkEn, x_inCredit, x_outFlit, x_outValid,
           y_inFlit, y_inValid, y_outCredit, bypFlitCount, dbgState
  );
endinterface

// File: rtl/vc_router_bypass_pipe.sv
// Router bypass shim. It sits between the fabric links (x side) and one VC
// router (y side).
// NORMAL: flits and credits pass straight between x and y.
// BYPASS: each x input channel loops back to the same-index x output
//         through a BYP_STAGES-deep register pipe, and the router clock is
//         gated off.
// Mode changes go through a quiesce state. The switch only happens after
// QUIET_CYCLES consecutive idle cycles, so no flit or credit is lost or
// duplicated. Leaving bypass also requires the pipe to be empty.
//
// Ports:
//   clk    sole clock
//   reset  asynchronous, active-high reset
//   io     vc_router_bypass_pipe_if.slave (all data, control and status)
//
// BYP_STAGES must be in 1..4. QUIET_CYCLES must be at least 1.
module vc_router_bypass_pipe #(
  parameter int NUM_CH       = 5,
  parameter int NUM_VC       = 2,
  parameter int FLIT_W       = 55,
  parameter int BYP_STAGES   = 1,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  vc_router_bypass_pipe_if.slave  io
);

  localparam int CW = NUM_CH * NUM_VC;
  localparam int FW = NUM_CH * FLIT_W;
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYCLES);

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    Q2B    = 2'd1,
    BYPASS = 2'd2,
    Q2N    = 2'd3
  } state_t;

  state_t          state, stateNext;
  logic [QW-1:0]   quiet, quietIncl;
  logic            sel, clkEn;
  logic            idle, pipeEmpty;
  logic [31:0]     bypCount;

  logic [FW-1:0]     pipeFlit  [BYP_STAGES];
  logic [NUM_CH-1:0] pipeValid [BYP_STAGES];
  logic [CW-1:0]     pipeCred  [BYP_STAGES];

  // Idle means nothing moves in either direction on either side.
  assign idle = ~(|io.x_inValid) & ~(|io.y_outValid) &
                ~(|io.x_outCredit) & ~(|io.y_inCredit);

  // Quiet count including the current cycle. A mode switch needs the
  // switching cycle itself to be idle as well.
  always_comb begin
    quietIncl = '0;
    if (idle) begin
      quietIncl = (quiet == QUIET_MAX) ? quiet : quiet + 1'b1;
    end
  end

  always_comb begin
    pipeEmpty = 1'b1;
    for (int s = 0; s < BYP_STAGES; s++) begin
      if ((|pipeValid[s]) || (|pipeCred[s])) pipeEmpty = 1'b0;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      NORMAL: if (io.bypassReq) stateNext = Q2B;
      Q2B: begin
        if (!io.bypassReq)                stateNext = NORMAL;
        else if (quietIncl == QUIET_MAX)  stateNext = BYPASS;
      end
      BYPASS: if (!io.bypassReq) stateNext = Q2N;
      Q2N: begin
        // The router clock is already running here, so that it is awake
        // before it gets traffic again.
        if (io.bypassReq)                              stateNext = BYPASS;
        else if (quietIncl == QUIET_MAX && pipeEmpty)  stateNext = NORMAL;
      end
      default: stateNext = NORMAL;
    endcase
  end

  // sel and clkEn are registered decodes of the next state, so they change
  // on the same edge that enters the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      sel   <= 1'b0;
      clkEn <= 1'b1;
      quiet <= '0;
    end else begin
      state <= stateNext;
      sel   <= (stateNext == BYPASS) || (stateNext == Q2N);
      clkEn <= (stateNext != BYPASS);
      quiet <= (stateNext != state) ? '0 : quietIncl;
    end
  end

  // Valid and credit bits load 0 when not in bypass, so NORMAL traffic
  // never enters the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < BYP_STAGES; s++) begin
        pipeValid[s] <= '0;
        pipeCred[s]  <= '0;
      end
    end else begin
      pipeValid[0] <= io.x_inValid & {NUM_CH{sel}};
      pipeCred[0]  <= io.x_outCredit & {CW{sel}};
      for (int s = 1; s < BYP_STAGES; s++) begin
        pipeValid[s] <= pipeValid[s-1] & {NUM_CH{sel}};
        pipeCred[s]  <= pipeCred[s-1] & {CW{sel}};
      end
    end
  end

  // Flit data is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    pipeFlit[0] <= io.x_inFlit;
    for (int s = 1; s < BYP_STAGES; s++) begin
      pipeFlit[s] <= pipeFlit[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypCount <= '0;
    end else if (sel) begin
      bypCount <= bypCount + 32'($countones(io.x_inValid));
    end
  end

  assign io.y_inFlit     = io.x_inFlit;
  assign io.y_inValid    = io.x_inValid & ~{NUM_CH{sel}};
  assign io.y_outCredit  = io.x_outCredit & ~{CW{sel}};
  assign io.x_outFlit    = sel ? pipeFlit[BYP_STAGES-1]  : io.y_outFlit;
  assign io.x_outValid   = sel ? pipeValid[BYP_STAGES-1] : io.y_outValid;
  assign io.x_inCredit   = sel ? pipeCred[BYP_STAGES-1]  : io.y_inCredit;
  assign io.bypassActive = sel;
  assign io.routerClkEn  = clkEn;
  assign io.bypFlitCount = bypCount;
  assign io.dbgState     = state;

endmodule
